val2_shifter_pipe: RTL and testbench
====================================

Name: val2_shifter_pipe

Overview:
Parametrised, pipelined successor to the combinational operand-2 generator in the ARM execute stage. Computes Val2 and the shifter carry-out for the three operand forms: memory offset, rotated immediate, and register shifted by immediate or by register (Rs). Sits between the ID/EX register and the ALU/status-register update. Uses a valid/ready handshake, carries a tag alongside each result, and supports branch flush.

Parameters:
DATA_W, 32, operand width; power of two, >= 32.
LATENCY, 1, pipeline depth in cycles (legal: 1 or 2); with 2, stage 1 registers decoded shift controls and stage 2 registers the result.
TAG_W, 4, width of the opaque tag passed through with each op.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  drops all in-flight ops; synchronous.
in_valid  in  1  input op present.
in_ready  out  1  unit accepts the op this cycle.
mem_cmd  in  1  1 = load/store offset form.
imm  in  1  I bit; 1 = rotated immediate.
shift_operand  in  12  instruction bits [11:0].
val_rm  in  DATA_W  Rm value.
val_rs  in  DATA_W  Rs value; only [7:0] are used.
c_in  in  1  current C flag.
in_tag  in  TAG_W  tag for the op.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result.
val2_out  out  DATA_W  operand 2.
carry_out  out  1  shifter carry.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: out_valid=0, val2_out=0, carry_out=0, out_tag=0, all internal stage valids=0. rst overrides flush and all inputs.
- Accept: an op is accepted when in_valid && in_ready.
- Stage advance rule: a stage captures new data when it is empty or its content is moving downstream that cycle.
- in_ready = !flush && (stage 1 empty || stage 1 advancing). When LATENCY=1, stage 1 is the output stage.
- Latency: the result appears LATENCY cycles after acceptance. Full throughput is one op per cycle while out_ready=1.
- Output stall: while out_valid && !out_ready, val2_out, carry_out and out_tag hold stable. Once every stage is full, in_ready=0.
- Flush: clears every stage valid bit, including out_valid, on the next edge. in_ready=0 during flush, so flush takes priority over a simultaneous in_valid.
- Field naming: rot=shift_operand[11:8], imm8=[7:0], sh_imm=[11:7], type=[6:5], rs_sel=[4]. N means DATA_W.
- Memory form (mem_cmd=1, overrides imm): val2 = zero-extended shift_operand; carry = c_in.
- Rotated immediate (imm=1): val2 = zero-extended imm8 rotated right by 2*rot within N bits. Carry = c_in if rot==0, else val2[N-1].
- Register shifted by immediate (imm=0, rs_sel=0):
  - LSL: amount 0 gives val2=Rm, carry=c_in; otherwise carry = last bit shifted out.
  - LSR/ASR: amount 0 encodes a shift by N. LSR gives 0 with carry=Rm[N-1]; ASR gives all bits = Rm[N-1] with carry=Rm[N-1].
  - ROR: amount 0 means RRX, val2 = {c_in, Rm[N-1:1]}, carry=Rm[0].
- Register shifted by register (imm=0, rs_sel=1), amount s = val_rs[7:0]:
  - s==0, any type: val2=Rm, carry=c_in.
  - LSL: s<N gives normal shift; s==N gives 0, carry=Rm[0]; s>N gives 0, carry=0.
  - LSR: s<N gives normal shift; s==N gives 0, carry=Rm[N-1]; s>N gives 0, carry=0.
  - ASR: s>=N gives all bits = Rm[N-1], carry=Rm[N-1].
  - ROR: effective amount = s mod N. If that is 0 (and s!=0), val2=Rm, carry=Rm[N-1]; otherwise rotate right, carry=val2[N-1].
- Tag: in_tag travels unchanged with its op.
- Out-of-range parameter: LATENCY other than 1 or 2 is an elaboration error.

Test Plan:
- Rotated immediate: imm=1, rot=4'h1, imm8=8'hFF, c_in=0 -> val2_out=32'hC000003F, carry_out=1, valid LATENCY cycles after accept.
- RRX: imm=0, shift_operand=12'h060, Rm=32'h00000003, c_in=1 -> val2_out=32'h80000001, carry_out=1.
- Register shift: rs_sel=1, LSL, Rs=32, Rm=32'h00000001 -> val2_out=0, carry=1. Repeat with Rs=33 -> val2_out=0, carry=0. ASR with Rs=40, Rm=32'h80000000 -> val2_out=32'hFFFFFFFF, carry=1.
- Backpressure, LATENCY=2: stream tags 1..6 with out_ready=0 for 4 cycles. Required: in_ready drops once both stages are full, outputs hold stable, all tags then emerge in order with none lost or duplicated.
- Flush: assert flush with both stages full and in_valid=1. Next cycle out_valid=0 and the flushed ops never appear. The concurrent input is not accepted (in_ready=0).
- Reset mid-stream: assert rst while out_valid=1 and flush=1. Next cycle all outputs are 0 and no stale result appears after rst is released.

Source files
------------

// File: rtl/val2_shifter_pipe.sv
// Operand-2 generator for the execute stage: memory offset, rotated immediate,
// and register shifted by immediate or by Rs. Pipelined (1 or 2 stages) with
// a valid/ready handshake, tag pass-through and synchronous flush.
module val2_shifter_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_cmd,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_rs,
  input  logic              c_in,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              carry_out,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int AW = $clog2(DATA_W);

  // Every form collapses to either a plain pass-through or one real shift by
  // an amount in 1..N-1, so stage 2 only needs a single barrel shifter.
  typedef enum logic [2:0] {K_PASS, K_LSL, K_LSR, K_ASR, K_ROR} kind_e;

  typedef struct packed {
    kind_e             kind;
    logic [AW-1:0]     amt;
    logic [DATA_W-1:0] data;
    logic              cin;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              carry;
  } res_t;

  ctrl_t       dec;
  logic [7:0]  s;
  logic [3:0]  rot;
  logic [4:0]  sh_imm;
  logic [1:0]  sh_type;
  logic        rs_sel;
  logic        msb;
  logic        unused_rs;

  assign s         = val_rs[7:0];
  assign rot       = shift_operand[11:8];
  assign sh_imm    = shift_operand[11:7];
  assign sh_type   = shift_operand[6:5];
  assign rs_sel    = shift_operand[4];
  assign msb       = val_rm[DATA_W-1];
  assign unused_rs = ^val_rs[DATA_W-1:8];

  // Decode operand form and shift amount into a pass/shift control word
  always_comb begin
    dec      = '0;
    dec.kind = K_PASS;
    dec.data = val_rm;
    dec.cin  = c_in;
    if (mem_cmd) begin
      dec.data = DATA_W'(shift_operand);
    end else if (imm) begin
      dec.data = DATA_W'(shift_operand[7:0]);
      if (rot != 4'd0) begin
        dec.kind = K_ROR;
        dec.amt  = AW'({rot, 1'b0});
      end
    end else if (!rs_sel) begin
      dec.amt = AW'(sh_imm);
      case (sh_type)
        2'b00: if (sh_imm != 5'd0) dec.kind = K_LSL;
        2'b01: begin
          if (sh_imm != 5'd0) dec.kind = K_LSR;
          else begin dec.data = '0; dec.cin = msb; end
        end
        2'b10: begin
          if (sh_imm != 5'd0) dec.kind = K_ASR;
          else begin dec.data = {DATA_W{msb}}; dec.cin = msb; end
        end
        default: begin
          if (sh_imm != 5'd0) dec.kind = K_ROR;
          else begin dec.data = {c_in, val_rm[DATA_W-1:1]}; dec.cin = val_rm[0]; end
        end
      endcase
    end else if (s != 8'd0) begin
      dec.amt = AW'(s);
      case (sh_type)
        2'b00: begin
          if (int'(s) < DATA_W) dec.kind = K_LSL;
          else begin dec.data = '0; dec.cin = (int'(s) == DATA_W) ? val_rm[0] : 1'b0; end
        end
        2'b01: begin
          if (int'(s) < DATA_W) dec.kind = K_LSR;
          else begin dec.data = '0; dec.cin = (int'(s) == DATA_W) ? msb : 1'b0; end
        end
        2'b10: begin
          if (int'(s) < DATA_W) dec.kind = K_ASR;
          else begin dec.data = {DATA_W{msb}}; dec.cin = msb; end
        end
        default: begin
          // Low AW bits of s are s mod N; a multiple of N leaves Rm untouched
          if (dec.amt != '0) dec.kind = K_ROR;
          else dec.cin = msb;
        end
      endcase
    end
  end

  // Barrel shift: amt is guaranteed nonzero and below N for shift kinds
  function automatic res_t exec(input ctrl_t c);
    res_t r;
    r.val   = c.data;
    r.carry = c.cin;
    case (c.kind)
      K_LSL: begin
        r.val   = c.data << c.amt;
        r.carry = c.data[DATA_W - int'(c.amt)];
      end
      K_LSR: begin
        r.val   = c.data >> c.amt;
        r.carry = c.data[c.amt - 1'b1];
      end
      K_ASR: begin
        r.val   = DATA_W'($signed(c.data) >>> c.amt);
        r.carry = c.data[c.amt - 1'b1];
      end
      K_ROR: begin
        r.val   = (c.data >> c.amt) | (c.data << (DATA_W - int'(c.amt)));
        r.carry = r.val[DATA_W-1];
      end
      default: ;
    endcase
    return r;
  endfunction

  logic             out_vld_q;
  res_t             out_res_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_adv;

  assign out_adv   = !out_vld_q || out_ready;
  assign out_valid = out_vld_q;
  assign val2_out  = out_res_q.val;
  assign carry_out = out_res_q.carry;
  assign out_tag   = out_tag_q;

  if (LATENCY == 1) begin : g_lat1
    assign in_ready = !flush && out_adv;

    // Single stage: decode and shift in one cycle, straight into the output
    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld_q <= 1'b0;
        out_res_q <= '0;
        out_tag_q <= '0;
      end else if (flush) begin
        out_vld_q <= 1'b0;
      end else if (out_adv) begin
        out_vld_q <= in_valid;
        if (in_valid) begin
          out_res_q <= exec(dec);
          out_tag_q <= in_tag;
        end
      end
    end
  end else if (LATENCY == 2) begin : g_lat2
    logic             s1_vld_q;
    ctrl_t            s1_ctrl_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_adv;

    assign s1_adv   = !s1_vld_q || out_adv;
    assign in_ready = !flush && s1_adv;

    // Stage 1: register decoded shift controls
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_vld_q  <= 1'b0;
        s1_ctrl_q <= '0;
        s1_tag_q  <= '0;
      end else if (flush) begin
        s1_vld_q <= 1'b0;
      end else if (s1_adv) begin
        s1_vld_q <= in_valid;
        if (in_valid) begin
          s1_ctrl_q <= dec;
          s1_tag_q  <= in_tag;
        end
      end
    end

    // Stage 2: shift and register the result
    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld_q <= 1'b0;
        out_res_q <= '0;
        out_tag_q <= '0;
      end else if (flush) begin
        out_vld_q <= 1'b0;
      end else if (out_adv) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_res_q <= exec(s1_ctrl_q);
          out_tag_q <= s1_tag_q;
        end
      end
    end
  end else begin : g_bad_latency
    $error("val2_shifter_pipe: LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Directed bench: function vectors on LATENCY=1 and LATENCY=2 instances fed
// in parallel, then backpressure, flush and reset on the LATENCY=2 instance.
module tb_val2_shifter_pipe;

  logic        clk, rst, flush, in_valid, mem_cmd, imm, c_in;
  logic [11:0] shift_operand;
  logic [31:0] val_rm, val_rs;
  logic [3:0]  in_tag;
  logic        out_ready, rdy1;

  logic        ir1, ov1, co1, ir2, ov2, co2;
  logic [31:0] v1, v2;
  logic [3:0]  t1, t2;

  int n_chk, n_fail;
  logic [3:0] seen[$];

  val2_shifter_pipe #(.DATA_W(32), .LATENCY(1), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .mem_cmd(mem_cmd), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .c_in(c_in), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(rdy1), .val2_out(v1), .carry_out(co1), .out_tag(t1));

  val2_shifter_pipe #(.DATA_W(32), .LATENCY(2), .TAG_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .mem_cmd(mem_cmd), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .c_in(c_in), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(out_ready), .val2_out(v2), .carry_out(co2), .out_tag(t2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every tag handed off by the LATENCY=2 instance
  always @(negedge clk) if (!rst && ov2 && out_ready) seen.push_back(t2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string nm, input logic m, input logic i, input logic [11:0] so,
                      input logic [31:0] rm, input logic [31:0] rs, input logic c,
                      input logic [3:0] t, input logic [31:0] ev, input logic ec);
    mem_cmd = m; imm = i; shift_operand = so; val_rm = rm; val_rs = rs; c_in = c;
    in_tag = t; in_valid = 1'b1;
    #1;
    chk({nm, " in_ready"}, 64'(ir2), 64'd1);
    step();
    in_valid = 1'b0;
    chk({nm, " L1 valid"}, 64'(ov1), 64'd1);
    chk({nm, " L1 val2"}, 64'(v1), 64'(ev));
    chk({nm, " L1 carry"}, 64'(co1), 64'(ec));
    chk({nm, " L1 tag"}, 64'(t1), 64'(t));
    chk({nm, " L2 early valid"}, 64'(ov2), 64'd0);
    step();
    chk({nm, " L2 valid"}, 64'(ov2), 64'd1);
    chk({nm, " L2 val2"}, 64'(v2), 64'(ev));
    chk({nm, " L2 carry"}, 64'(co2), 64'(ec));
    chk({nm, " L2 tag"}, 64'(t2), 64'(t));
  endtask

  initial begin
    int next, cyc;
    logic acc;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_cmd = 1'b0; imm = 1'b0; c_in = 1'b0;
    shift_operand = '0; val_rm = '0; val_rs = '0; in_tag = '0; out_ready = 1'b1; rdy1 = 1'b1;
    step(); step();
    chk("rst out_valid", 64'(ov2), 64'd0);
    chk("rst val2", 64'(v2), 64'd0);
    chk("rst carry", 64'(co2), 64'd0);
    chk("rst tag", 64'(t2), 64'd0);
    chk("rst L1 out_valid", 64'(ov1), 64'd0);
    rst = 1'b0;
    step();
    chk("idle in_ready", 64'(ir2), 64'd1);

    // name, mem, imm, shift_operand, Rm, Rs, c_in, tag, expected val2, expected carry
    send("rotimm",   1'b0, 1'b1, 12'h1FF, 32'h0,        32'h0,   1'b0, 4'h1, 32'hC000003F, 1'b1);
    send("rotimm0",  1'b0, 1'b1, 12'h080, 32'h0,        32'h0,   1'b1, 4'h2, 32'h00000080, 1'b1);
    send("rrx",      1'b0, 1'b0, 12'h060, 32'h00000003, 32'h0,   1'b1, 4'h3, 32'h80000001, 1'b1);
    send("lslrs32",  1'b0, 1'b0, 12'h010, 32'h00000001, 32'd32,  1'b0, 4'h4, 32'h00000000, 1'b1);
    send("lslrs33",  1'b0, 1'b0, 12'h010, 32'h00000001, 32'd33,  1'b1, 4'h5, 32'h00000000, 1'b0);
    send("asrrs40",  1'b0, 1'b0, 12'h050, 32'h80000000, 32'd40,  1'b0, 4'h6, 32'hFFFFFFFF, 1'b1);
    send("mem",      1'b1, 1'b1, 12'hABC, 32'hFFFFFFFF, 32'h0,   1'b1, 4'h7, 32'h00000ABC, 1'b1);
    send("lslimm4",  1'b0, 1'b0, 12'h200, 32'hF0000001, 32'h0,   1'b0, 4'h8, 32'h00000010, 1'b1);
    send("lsrimm0",  1'b0, 1'b0, 12'h020, 32'h80000000, 32'h0,   1'b0, 4'h9, 32'h00000000, 1'b1);
    send("asrimm0",  1'b0, 1'b0, 12'h040, 32'h40000000, 32'h0,   1'b1, 4'hA, 32'h00000000, 1'b0);
    send("rorrs36",  1'b0, 1'b0, 12'h070, 32'h0000000F, 32'd36,  1'b0, 4'hB, 32'hF0000000, 1'b1);
    send("rorrs32",  1'b0, 1'b0, 12'h070, 32'h7FFFFFFF, 32'd32,  1'b1, 4'hC, 32'h7FFFFFFF, 1'b0);
    send("rs0",      1'b0, 1'b0, 12'h030, 32'h12345678, 32'h100, 1'b1, 4'hD, 32'h12345678, 1'b1);
    send("lsrrs4",   1'b0, 1'b0, 12'h030, 32'h0000001F, 32'd4,   1'b0, 4'hE, 32'h00000001, 1'b1);
    send("lsrrs32",  1'b0, 1'b0, 12'h030, 32'h80000000, 32'd32,  1'b0, 4'hF, 32'h00000000, 1'b1);
    step(); step();

    // Backpressure: tags 1..6 as rotated immediates whose value equals the tag
    seen.delete();
    mem_cmd = 1'b0; imm = 1'b1; c_in = 1'b0;
    next = 1; cyc = 0;
    while ((next <= 6 || seen.size() < 6) && cyc < 100) begin
      out_ready = (cyc >= 4);
      in_valid = (next <= 6);
      in_tag = 4'(next);
      shift_operand = 12'(next);
      #1;
      acc = in_valid && ir2;
      if (cyc == 2) begin
        chk("bp in_ready full", 64'(ir2), 64'd0);
        chk("bp out_valid", 64'(ov2), 64'd1);
        chk("bp tag hold", 64'(t2), 64'd1);
      end
      if (cyc == 3) begin
        chk("bp val2 hold", 64'(v2), 64'd1);
        chk("bp tag hold2", 64'(t2), 64'd1);
        chk("bp in_ready still 0", 64'(ir2), 64'd0);
      end
      @(posedge clk);
      if (acc) next++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp count", 64'(seen.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      chk("bp order", 64'(k < seen.size() ? seen[k] : 4'h0), 64'(k + 1));
    step(); step();

    // Flush with both stages full and a concurrent input
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'h9; shift_operand = 12'h009; step();
    in_tag = 4'hA; shift_operand = 12'h00A; step();
    chk("fl full out_valid", 64'(ov2), 64'd1);
    seen.delete();
    flush = 1'b1; in_tag = 4'hB; shift_operand = 12'h00B;
    #1;
    chk("fl in_ready", 64'(ir2), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl out_valid", 64'(ov2), 64'd0);
    repeat (4) step();
    chk("fl nothing emerges", 64'(seen.size()), 64'd0);

    // Reset mid-stream with flush also asserted
    out_ready = 1'b0;
    mem_cmd = 1'b1; c_in = 1'b1; shift_operand = 12'h5A5; in_tag = 4'h5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rs pre out_valid", 64'(ov2), 64'd1);
    chk("rs pre val2", 64'(v2), 64'h5A5);
    rst = 1'b1; flush = 1'b1;
    step();
    chk("rs out_valid", 64'(ov2), 64'd0);
    chk("rs val2", 64'(v2), 64'd0);
    chk("rs carry", 64'(co2), 64'd0);
    chk("rs tag", 64'(t2), 64'd0);
    seen.delete();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("rs no stale", 64'(seen.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
